chip_clock_phase_calibrator: RTL

Automatic phase-selection controller for the chip clock generator in the fast-readout path. Sweeps the chip-clock phase select over all available phases, counts correctly decoded idle/comma words received from the chip at each phase over a fixed window, then applies the best phase and reports lock. Sits in the `clock` domain between the run-control registers and the clock generator's `phaseshift_chip_clock` input.

---
 rtl/chip_clock_phase_calibrator_if.sv | 33 +++
 rtl/chip_clock_phase_calibrator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/chip_clock_phase_calibrator_if.sv
// Control/status bundle for the chip-clock phase calibrator.
// master drives run-control and decoder samples; slave is the calibrator.
interface chip_clock_phase_calibrator_if #(
  parameter int PHASE_W = 1,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               abort;
  logic               manual_load;
  logic [PHASE_W-1:0] manual_phase;
  logic               sample_valid;
  logic               sample_ok;
  logic [PHASE_W-1:0] phase_sel;
  logic               busy;
  logic               done;
  logic               locked;
  logic [PHASE_W-1:0] best_phase;
  logic [CNT_W-1:0]   best_count;

  modport master (
    output start, abort, manual_load, manual_phase,
    output sample_valid, sample_ok,
    input  phase_sel, busy, done, locked,
    input  best_phase, best_count
  );

  modport slave (
    input  start, abort, manual_load, manual_phase,
    input  sample_valid, sample_ok,
    output phase_sel, busy, done, locked,
    output best_phase, best_count
  );
endinterface

// File: rtl/chip_clock_phase_calibrator.sv
// Sweeps chip-clock phases, scores comma matches per window,
// then applies the best phase and reports lock.
module chip_clock_phase_calibrator #(
  parameter int NUM_PHASES     = 2,
  parameter int PHASE_W        = 1,
  parameter int SETTLE_CYCLES  = 16,
  parameter int WINDOW_LEN     = 1024,
  parameter int CNT_W          = 16,
  parameter int LOCK_THRESHOLD = 512
) (
  input  logic clock,
  input  logic reset,
  chip_clock_phase_calibrator_if.slave bus
);

  localparam int TMAX = (SETTLE_CYCLES > WINDOW_LEN) ?
                        SETTLE_CYCLES : WINDOW_LEN;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SET_END = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WIN_END = TW'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NUM_PHASES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    COMPARE
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_sel_q, phase_sel_d;
  logic [PHASE_W-1:0] prev_phase_q, prev_phase_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               locked_q, locked_d;
  logic [PHASE_W-1:0] best_phase_q, best_phase_d;
  logic [CNT_W-1:0]   best_count_q, best_count_d;

  logic [CNT_W-1:0]   win_count;
  logic [PHASE_W-1:0] win_phase;
  logic               man_ok;
  logic               hit;

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    phase_sel_d  = phase_sel_q;
    prev_phase_d = prev_phase_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    locked_d     = locked_q;
    best_phase_d = best_phase_q;
    best_count_d = best_count_q;

    // strict compare: a tie keeps the earlier (lower) phase
    win_count = best_count_q;
    win_phase = best_phase_q;
    if (cnt_q > best_count_q) begin
      win_count = cnt_q;
      win_phase = phase_sel_q;
    end

    man_ok = bus.manual_phase <= LAST_PH;
    hit    = bus.sample_valid & bus.sample_ok;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          prev_phase_d = phase_sel_q;
          phase_sel_d  = '0;
          busy_d       = 1'b1;
          cnt_d        = '0;
          best_count_d = '0;
          best_phase_d = '0;
          tmr_d        = '0;
          state_d      = SETTLE;
        end else if (bus.manual_load && !bus.start && man_ok) begin
          phase_sel_d = bus.manual_phase;
          locked_d    = 1'b0;
        end
      end
      SETTLE: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == SET_END) begin
          tmr_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        tmr_d = tmr_q + 1'b1;
        if (hit && cnt_q != CNT_MAX)
          cnt_d = cnt_q + 1'b1;
        if (tmr_q == WIN_END) begin
          tmr_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        best_count_d = win_count;
        best_phase_d = win_phase;
        if (phase_sel_q == LAST_PH) begin
          phase_sel_d = win_phase;
          locked_d    = 32'(win_count) >= 32'(LOCK_THRESHOLD);
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          phase_sel_d = phase_sel_q + 1'b1;
          cnt_d       = '0;
          state_d     = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // abort restores the phase in use before the sweep
    if (state_q != IDLE && bus.abort) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      locked_d     = 1'b0;
      phase_sel_d  = prev_phase_q;
      best_count_d = best_count_q;
      best_phase_d = best_phase_q;
      cnt_d        = cnt_q;
      tmr_d        = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      cnt_q        <= '0;
      phase_sel_q  <= '0;
      prev_phase_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      locked_q     <= 1'b0;
      best_phase_q <= '0;
      best_count_q <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      phase_sel_q  <= phase_sel_d;
      prev_phase_q <= prev_phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      locked_q     <= locked_d;
      best_phase_q <= best_phase_d;
      best_count_q <= best_count_d;
    end
  end

  assign bus.phase_sel  = phase_sel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.locked     = locked_q;
  assign bus.best_phase = best_phase_q;
  assign bus.best_count = best_count_q;

endmodule
